// File: rtl/ifu_axi_fetch.sv
// Instruction-fetch unit: AXI-lite read master on instruction memory, hands {pc, instruction}
// to decode over valid/ready, and waits for the next PC from writeback/branch logic.
module ifu_axi_fetch #(
   parameter logic [31:0] RESET_PC       = 32'h8000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] araddr,
   output logic        arvalid,
   input  logic        arready,
   input  logic [31:0] rdata,
   input  logic        rvalid,
   input  logic [1:0]  rresp,
   output logic        rready,
   output logic [31:0] inst_out,
   output logic [31:0] pc_out,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic        fetch_err,
   input  logic [31:0] next_pc,
   input  logic        next_pc_valid,
   output logic [31:0] fetch_count
);

   typedef enum logic [1:0] {
      S_AR   = 2'd0,
      S_R    = 2'd1,
      S_OUT  = 2'd2,
      S_WAIT = 2'd3
   } state_t;

   localparam bit          LP_TO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [31:0] LP_TO_LAST = 32'(TIMEOUT_CYCLES - 1);

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_pc;
   logic [31:0] r_inst;
   logic [31:0] r_pc_out;
   logic        r_err;
   logic [31:0] r_count;
   logic [31:0] r_timer;
   logic        w_timeout;

   assign w_timeout = LP_TO_EN && (r_timer == LP_TO_LAST) && !rvalid;

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_AR;
      else     r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_AR:    if (arready) w_next = S_R; else w_next = S_AR;
         S_R:     if (rvalid || w_timeout) w_next = S_OUT; else w_next = S_R;
         S_OUT: begin
            if (inst_ready && next_pc_valid) w_next = S_AR;
            else if (inst_ready)             w_next = S_WAIT;
            else                             w_next = S_OUT;
         end
         S_WAIT:  if (next_pc_valid) w_next = S_AR; else w_next = S_WAIT;
         default: w_next = S_AR;
      endcase
   end

   // Handshake outputs decoded straight from the state register
   always_comb begin
      arvalid    = 1'b0;
      rready     = 1'b0;
      inst_valid = 1'b0;
      case (r_state)
         S_AR:    begin arvalid = 1'b1; rready = 1'b1; end
         S_R:     rready = 1'b1;
         S_OUT:   inst_valid = 1'b1;
         S_WAIT:  arvalid = 1'b0;
         default: arvalid = 1'b0;
      endcase
   end

   // Datapath: PC, captured instruction, error flag, timer and accept counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc     <= RESET_PC;
         r_inst   <= 32'h0000_0000;
         r_pc_out <= 32'h0000_0000;
         r_err    <= 1'b0;
         r_count  <= 32'h0000_0000;
         r_timer  <= 32'h0000_0000;
      end else begin
         case (r_state)
            S_AR: begin
               if (arready) r_timer <= 32'h0000_0000;
            end
            S_R: begin
               if (rvalid) begin
                  r_inst   <= rdata;
                  r_pc_out <= r_pc;
                  r_err    <= (rresp != 2'b00);
               end else if (w_timeout) begin
                  r_inst   <= 32'h0000_0000;
                  r_pc_out <= r_pc;
                  r_err    <= 1'b1;
               end else begin
                  r_timer  <= r_timer + 32'h0000_0001;
               end
            end
            S_OUT: begin
               if (inst_ready) begin
                  r_count <= r_count + 32'h0000_0001;
                  if (next_pc_valid) r_pc <= next_pc;
               end
            end
            S_WAIT: begin
               if (next_pc_valid) r_pc <= next_pc;
            end
            default: r_pc <= r_pc;
         endcase
      end
   end

   assign araddr      = r_pc;
   assign inst_out    = r_inst;
   assign pc_out      = r_pc_out;
   assign fetch_err   = r_err;
   assign fetch_count = r_count;

endmodule

// File: doc/ifu_axi_fetch.md
Name: ifu_axi_fetch

Overview:
- Instruction-fetch unit for the multicycle core.
- Acts as the AXI-lite read master on the instruction memory: drives araddr/arvalid, consumes rdata/rvalid/rresp.
- Hands {pc, instruction} to the decode stage over a valid/ready pair.
- Accepts the next PC from the writeback/branch logic before starting the next fetch.
- Sits directly upstream of the instruction memory read channel and feeds decode.

Parameters:
- RESET_PC, 32'h8000_0000, PC loaded on reset; first fetch address.
- TIMEOUT_CYCLES, 255, max cycles in S_R waiting for rvalid; 0 disables the timeout.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- araddr  output  32  read address, equals pc_q
- arvalid  output  1  read address valid
- arready  input  1  read address ready
- rdata  input  32  read data
- rvalid  input  1  read data valid
- rresp  input  2  read response, 2'b00 = OKAY
- rready  output  1  read data ready
- inst_out  output  32  fetched instruction
- pc_out  output  32  PC of inst_out
- inst_valid  output  1  instruction available to decode
- inst_ready  input  1  decode accepts the instruction
- fetch_err  output  1  qualifies inst_out: bad rresp or timeout
- next_pc  input  32  PC for the next fetch
- next_pc_valid  input  1  next_pc is valid (single-cycle pulse or level)
- fetch_count  output  32  number of instructions accepted by decode

Behaviour:
- All outputs are driven from registers or from the state register.
- States:
  - S_AR: arvalid=1, rready=1.
  - S_R: rready=1.
  - S_OUT: inst_valid=1.
  - S_WAIT: waiting for next_pc.
- rready is also high in S_AR because the memory launches its read only when arvalid, arready and rready are high in the same cycle.
- Reset values:
  - state=S_AR; pc_q=RESET_PC.
  - inst_out=0, pc_out=0, fetch_err=0, fetch_count=0, timer=0.
  - With state=S_AR, arvalid=1 and rready=1 from the first cycle after reset.
- S_AR:
  - arvalid && arready -> S_R; timer cleared.
  - araddr is held stable while arvalid=1 and arready=0.
  - rvalid seen in S_AR is ignored.
- S_R, on rvalid:
  - Latch inst_out=rdata, pc_out=pc_q, fetch_err=(rresp!=0), then -> S_OUT.
  - Minimum latency from AR handshake to inst_valid is 2 cycles: rvalid the cycle after the handshake, inst_valid the cycle after that.
- S_R, no rvalid:
  - timer increments each cycle.
  - If TIMEOUT_CYCLES!=0 and timer reaches TIMEOUT_CYCLES-1 without rvalid: inst_out=0, pc_out=pc_q, fetch_err=1, -> S_OUT.
  - After a timeout, a late rvalid is ignored because rready=0 outside S_AR/S_R.
- S_OUT:
  - inst_out, pc_out and fetch_err are held stable while inst_valid=1 and inst_ready=0.
  - inst_ready && next_pc_valid in the same cycle: pc_q=next_pc, fetch_count++, -> S_AR.
  - inst_ready only: fetch_count++, -> S_WAIT.
  - next_pc_valid without inst_ready: ignored; next_pc is not captured.
- S_WAIT: on next_pc_valid, pc_q=next_pc, -> S_AR.
- next_pc_valid in S_AR or S_R is ignored.
- next_pc is taken as-is; no alignment check. Misaligned PCs are the decoder/trap logic's concern.
- fetch_count wraps 32'hFFFF_FFFF -> 0.
- Reset mid-operation, in any state:
  - Next cycle: state=S_AR, pc_q=RESET_PC, inst_valid=0, fetch_count=0.
  - Any in-flight rvalid is ignored because it arrives in S_AR.
- No write channel: this block never drives awvalid or wvalid; the top level ties those to 0.

Test Plan:
- Reset, zero-wait memory (arready=1, rvalid one cycle after handshake, rdata=32'h0000_0413) -> araddr=32'h8000_0000; inst_valid rises 2 cycles after the handshake with inst_out=32'h0000_0413, pc_out=32'h8000_0000, fetch_err=0.
- Hold arready=0 for 3 cycles -> arvalid=1 and araddr stable for all 3 cycles; handshake on cycle 4; no premature S_R.
- inst_ready=0 for 5 cycles, then inst_ready and next_pc_valid together with next_pc=32'h8000_0004 -> outputs stable for 5 cycles; next cycle arvalid=1, araddr=32'h8000_0004; fetch_count=1.
- inst_ready accepted, next_pc_valid arrives 4 cycles later with 32'h8000_0100 -> arvalid stays 0 while in S_WAIT; then araddr=32'h8000_0100.
- rresp=2'b10 with rdata=32'hDEAD_BEEF -> inst_out=32'hDEAD_BEEF, fetch_err=1.
- TIMEOUT_CYCLES=4 and no rvalid -> after 4 cycles in S_R: inst_valid=1, inst_out=0, fetch_err=1. A later rvalid is ignored.
- Assert rst while in S_OUT -> next cycle inst_valid=0, arvalid=1, araddr=32'h8000_0000, fetch_count=0.
